// File: rtl/ahb_bus_matrix_arbiter_rr_pkg.sv
// Shared types for the bus-matrix round-robin output-stage arbiter.
// Holds the HTRANS/HBURST encodings, the FSM state type and a burst-length helper.
package ahb_bus_matrix_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LOCKED,
    ST_BURST
  } arb_state_e;

  // Beats remaining after the first one; 0 for SINGLE and undefined INCR.
  function automatic logic [3:0] burst_beats_m1(
    input logic [2:0] hburst
  );
    logic [3:0] n;
    n = 4'd0;
    case (hburst)
      HB_WRAP4,  HB_INCR4:  n = 4'd3;
      HB_WRAP8,  HB_INCR8:  n = 4'd7;
      HB_WRAP16, HB_INCR16: n = 4'd15;
      default:              n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_bus_matrix_arbiter_rr_if.sv
// Output-stage arbitration bundle: requests and granted-port controls in,
// address/data mux selects and one-hot ownership out.
// slave = arbiter side, master = input-stage / output-stage side.
interface ahb_bus_matrix_arbiter_rr_if #(
  parameter int NUM_PORTS  = 3,
  parameter int PORT_IDX_W = 2
) ();

  logic [NUM_PORTS-1:0]  req_port;
  logic                  HREADYM;
  logic [1:0]            HTRANSM;
  logic [2:0]            HBURSTM;
  logic                  HMASTLOCKM;
  logic [PORT_IDX_W-1:0] addr_in_port;
  logic                  no_port;
  logic [PORT_IDX_W-1:0] data_in_port;
  logic                  data_no_port;
  logic [NUM_PORTS-1:0]  active_port;

  modport slave (
    input  req_port, HREADYM, HTRANSM,
    input  HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port,
    output data_in_port, data_no_port,
    output active_port
  );

  modport master (
    output req_port, HREADYM, HTRANSM,
    output HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port,
    input  data_in_port, data_no_port,
    input  active_port
  );

endinterface

// File: rtl/ahb_bus_matrix_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: search starts at last_grant+1.
// Ports: req, last_grant in; winner index and any_req out.
module ahb_bus_matrix_rr_pick #(
  parameter int NUM_PORTS  = 3,
  parameter int PORT_IDX_W = 2
) (
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [PORT_IDX_W-1:0] last_grant,
  output logic [PORT_IDX_W-1:0] winner,
  output logic                  any_req
);

  int unsigned idx;

  // Walk from the farthest offset down so the nearest request wins;
  // offset NUM_PORTS is the previous owner, considered last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NUM_PORTS;
      if (req[idx]) begin
        winner  = PORT_IDX_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_matrix_arbiter_rr.sv
// Round-robin arbiter for one bus-matrix output stage; holds through locks and
// (with AHB_BUS_MATRIX_BURST_HOLD_EN) fixed-length bursts. Ports: HCLK, HRESET, bus.
import ahb_bus_matrix_pkg::*;

module ahb_bus_matrix_arbiter_rr #(
  parameter int NUM_PORTS  = 3,
  parameter int PORT_IDX_W = 2
) (
  input logic                        HCLK,
  input logic                        HRESET,
  ahb_bus_matrix_arbiter_rr_if.slave bus
);

  logic [PORT_IDX_W-1:0] addr_in_port_q, addr_in_port_d;
  logic [PORT_IDX_W-1:0] data_in_port_q, data_in_port_d;
  logic [PORT_IDX_W-1:0] last_grant_q, last_grant_d;
  logic                  data_no_port_q, data_no_port_d;
  arb_state_e            state_q, state_d;

  logic [PORT_IDX_W-1:0] winner;
  logic                  any_req;
  logic                  no_port;
  logic                  lock_hold;
  logic                  burst_hold;
  logic [NUM_PORTS-1:0]  active;
  htrans_e               trans;

  assign trans     = htrans_e'(bus.HTRANSM);
  assign no_port   = (state_q == ST_IDLE);
  assign lock_hold = !no_port && bus.HMASTLOCKM
                     && (trans != HT_IDLE);

  ahb_bus_matrix_rr_pick #(
    .NUM_PORTS  (NUM_PORTS),
    .PORT_IDX_W (PORT_IDX_W)
  ) u_pick (
    .req        (bus.req_port),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

`ifdef AHB_BUS_MATRIX_BURST_HOLD_EN
  logic [3:0] cnt_q, cnt_d, cnt_upd;

  // cnt_upd is what remains once the current beat completes; holding on
  // it (not cnt_q) keeps the NONSEQ beat and releases on the last SEQ.
  always_comb begin
    cnt_upd = 4'd0;
    if (!no_port) begin
      case (trans)
        HT_NONSEQ: cnt_upd = burst_beats_m1(bus.HBURSTM);
        HT_SEQ:    cnt_upd = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        HT_BUSY:   cnt_upd = cnt_q;
        default:   cnt_upd = 4'd0;
      endcase
    end
    cnt_d = bus.HREADYM ? cnt_upd : cnt_q;
  end

  assign burst_hold = !no_port && (trans != HT_IDLE)
                      && (cnt_upd != 4'd0);
`else
  assign burst_hold = 1'b0;
`endif

  always_comb begin
    addr_in_port_d = addr_in_port_q;
    data_in_port_d = data_in_port_q;
    data_no_port_d = data_no_port_q;
    last_grant_d   = last_grant_q;
    state_d        = state_q;
    if (bus.HREADYM) begin
      data_in_port_d = addr_in_port_q;
      data_no_port_d = no_port;
      if (lock_hold) begin
        state_d = ST_LOCKED;
      end else if (burst_hold) begin
        state_d = ST_BURST;
      end else if (any_req) begin
        addr_in_port_d = winner;
        last_grant_d   = winner;
        state_d        = ST_GRANT;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_in_port_q <= '0;
      data_in_port_q <= '0;
      data_no_port_q <= 1'b1;
      last_grant_q   <= PORT_IDX_W'(NUM_PORTS - 1);
      state_q        <= ST_IDLE;
`ifdef AHB_BUS_MATRIX_BURST_HOLD_EN
      cnt_q          <= 4'd0;
`endif
    end else begin
      addr_in_port_q <= addr_in_port_d;
      data_in_port_q <= data_in_port_d;
      data_no_port_q <= data_no_port_d;
      last_grant_q   <= last_grant_d;
      state_q        <= state_d;
`ifdef AHB_BUS_MATRIX_BURST_HOLD_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      active[i] = !no_port
                  && (addr_in_port_q == PORT_IDX_W'(i));
    end
  end

  assign bus.addr_in_port = addr_in_port_q;
  assign bus.no_port      = no_port;
  assign bus.data_in_port = data_in_port_q;
  assign bus.data_no_port = data_no_port_q;
  assign bus.active_port  = active;

endmodule
